alu_op_sequencer: RTL and testbench

- Command-side initiator that drives the ALU's instruction register file write port (write enable, address, data) and collects the ALU's combinational result and flags.
- Accepts one operation {opcode, operand A, operand B} over a valid/ready handshake.
- Writes operand A to reg 1, operand B to reg 2 and the opcode to reg 0.
- Waits a programmable settle time, captures result and flags, and returns them over a valid/ready response channel.

---
 rtl/alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Writes {a, b, op} into the ALU register file, waits SETTLE_CYCLES,
//            captures result/flags and returns them on a valid/ready channel.
//            Optional macro ALU_SEQ_SKIP_UNCHANGED_EN skips redundant writes.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer #(
  parameter int OPERAND_WIDTH    = 8,
  parameter int INST_ADDR_LENGTH = 2,
  parameter int SETTLE_CYCLES    = 1,
  parameter int ERR_CNT_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [OPERAND_WIDTH-1:0]    cmd_op,
  input  logic [OPERAND_WIDTH-1:0]    cmd_a,
  input  logic [OPERAND_WIDTH-1:0]    cmd_b,
  output logic                        alu_write_en,
  output logic [INST_ADDR_LENGTH-1:0] alu_write_addr,
  output logic [OPERAND_WIDTH-1:0]    alu_write_data,
  input  logic [OPERAND_WIDTH-1:0]    alu_result,
  input  logic                        alu_error,
  input  logic                        alu_zero,
  input  logic                        alu_carry,
  input  logic                        alu_overflow,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [OPERAND_WIDTH-1:0]    rsp_result,
  output logic                        rsp_error,
  output logic                        rsp_zero,
  output logic                        rsp_carry,
  output logic                        rsp_overflow,
  output logic                        busy,
  output logic [ERR_CNT_WIDTH-1:0]    err_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_WR_OP  = 3'd3,
    S_SETTLE = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [INST_ADDR_LENGTH-1:0] c_ADDR_OP = INST_ADDR_LENGTH'(0);
  localparam logic [INST_ADDR_LENGTH-1:0] c_ADDR_A  = INST_ADDR_LENGTH'(1);
  localparam logic [INST_ADDR_LENGTH-1:0] c_ADDR_B  = INST_ADDR_LENGTH'(2);
  localparam logic [3:0]                  c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [OPERAND_WIDTH-1:0] r_op;
  logic [OPERAND_WIDTH-1:0] r_a;
  logic [OPERAND_WIDTH-1:0] r_b;
  logic [3:0]               r_cnt;
  logic [OPERAND_WIDTH-1:0] r_rsp_result;
  logic                     r_rsp_error;
  logic                     r_rsp_zero;
  logic                     r_rsp_carry;
  logic                     r_rsp_overflow;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_need_a;
  logic                     w_need_b;
  logic                     w_need_op;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd0);

`ifdef ALU_SEQ_SKIP_UNCHANGED_EN
  logic [OPERAND_WIDTH-1:0] r_sh_op;
  logic [OPERAND_WIDTH-1:0] r_sh_a;
  logic [OPERAND_WIDTH-1:0] r_sh_b;
  logic                     r_sh_op_vld;
  logic                     r_sh_a_vld;
  logic                     r_sh_b_vld;
  logic [OPERAND_WIDTH-1:0] w_cur_op;
  logic [OPERAND_WIDTH-1:0] w_cur_a;
  logic [OPERAND_WIDTH-1:0] w_cur_b;

  // In IDLE the decision is made on the incoming command, before it is latched.
  assign w_cur_op  = (r_state == S_IDLE) ? cmd_op : r_op;
  assign w_cur_a   = (r_state == S_IDLE) ? cmd_a  : r_a;
  assign w_cur_b   = (r_state == S_IDLE) ? cmd_b  : r_b;
  assign w_need_a  = !(r_sh_a_vld  && (r_sh_a  == w_cur_a));
  assign w_need_b  = !(r_sh_b_vld  && (r_sh_b  == w_cur_b));
  assign w_need_op = !(r_sh_op_vld && (r_sh_op == w_cur_op));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sh_op     <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_sh_op_vld <= 1'b0;
      r_sh_a_vld  <= 1'b0;
      r_sh_b_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_WR_A: begin
          r_sh_a     <= r_a;
          r_sh_a_vld <= 1'b1;
        end
        S_WR_B: begin
          r_sh_b     <= r_b;
          r_sh_b_vld <= 1'b1;
        end
        S_WR_OP: begin
          r_sh_op     <= r_op;
          r_sh_op_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign w_need_a  = 1'b1;
  assign w_need_b  = 1'b1;
  assign w_need_op = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    alu_write_en   = 1'b0;
    alu_write_addr = '0;
    alu_write_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_need_a)       w_next_state = S_WR_A;
          else if (w_need_b)  w_next_state = S_WR_B;
          else if (w_need_op) w_next_state = S_WR_OP;
          else                w_next_state = S_SETTLE;
        end
      end
      S_WR_A: begin
        alu_write_en   = 1'b1;
        alu_write_addr = c_ADDR_A;
        alu_write_data = r_a;
        if (w_need_b)       w_next_state = S_WR_B;
        else if (w_need_op) w_next_state = S_WR_OP;
        else                w_next_state = S_SETTLE;
      end
      S_WR_B: begin
        alu_write_en   = 1'b1;
        alu_write_addr = c_ADDR_B;
        alu_write_data = r_b;
        if (w_need_op) w_next_state = S_WR_OP;
        else           w_next_state = S_SETTLE;
      end
      S_WR_OP: begin
        alu_write_en   = 1'b1;
        alu_write_addr = c_ADDR_OP;
        alu_write_data = r_op;
        w_next_state   = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_capture) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= cmd_op;
      r_a  <= cmd_a;
      r_b  <= cmd_b;
    end
  end

  // Loaded on whichever edge enters SETTLE, so skipped writes still get a full settle window.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt <= 4'd0;
    end else if ((r_state != S_SETTLE) && (w_next_state == S_SETTLE)) begin
      r_cnt <= c_SETTLE_LOAD;
    end else if ((r_state == S_SETTLE) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rsp_result   <= '0;
      r_rsp_error    <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result   <= alu_result;
      r_rsp_error    <= alu_error;
      r_rsp_zero     <= alu_zero;
      r_rsp_carry    <= alu_carry;
      r_rsp_overflow <= alu_overflow;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_err_count <= '0;
    end else if ((r_state == S_RESP) && rsp_ready && r_rsp_error && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_result   = r_rsp_result;
  assign rsp_error    = r_rsp_error;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_overflow = r_rsp_overflow;
  assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// Bench for alu_op_sequencer: behavioural ALU register file, vector table with a
// response scoreboard on the default instance, and a SETTLE_CYCLES=3 instance.
module tb_alu_op_sequencer;

  localparam logic [7:0] OP_ADD    = 8'h00;
  localparam logic [7:0] OP_SUB    = 8'h01;
  localparam logic [7:0] OP_AND    = 8'h02;
  localparam logic [7:0] OP_OR     = 8'h03;
  localparam logic [7:0] OP_XOR    = 8'h04;
  localparam logic [7:0] OP_DIVIDE = 8'h05;
  localparam int         A_SETTLE  = 1;
`ifdef ALU_SEQ_SKIP_UNCHANGED_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic       cmd_valid, cmd_ready, alu_write_en, rsp_valid, rsp_ready, busy;
  logic [7:0] cmd_op, cmd_a, cmd_b, alu_write_data, alu_result, rsp_result, err_count;
  logic [1:0] alu_write_addr;
  logic       alu_error, alu_zero, alu_carry, alu_overflow;
  logic       rsp_error, rsp_zero, rsp_carry, rsp_overflow;

  logic       b_cmd_valid, b_cmd_ready, b_alu_write_en, b_rsp_valid, b_rsp_ready, b_busy;
  logic [7:0] b_cmd_op, b_cmd_a, b_cmd_b, b_alu_write_data, b_alu_result, b_rsp_result;
  logic [1:0] b_alu_write_addr, b_err_count;
  logic       b_alu_error, b_alu_zero, b_alu_carry, b_alu_overflow;
  logic       b_rsp_error, b_rsp_zero, b_rsp_carry, b_rsp_overflow;

  alu_op_sequencer u_dut (
    .clk(clk), .rstN(rstN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_write_en(alu_write_en), .alu_write_addr(alu_write_addr), .alu_write_data(alu_write_data),
    .alu_result(alu_result), .alu_error(alu_error), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .busy(busy), .err_count(err_count)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3), .ERR_CNT_WIDTH(2)) u_dut3 (
    .clk(clk), .rstN(rstN), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(b_cmd_op), .cmd_a(b_cmd_a), .cmd_b(b_cmd_b),
    .alu_write_en(b_alu_write_en), .alu_write_addr(b_alu_write_addr), .alu_write_data(b_alu_write_data),
    .alu_result(b_alu_result), .alu_error(b_alu_error), .alu_zero(b_alu_zero),
    .alu_carry(b_alu_carry), .alu_overflow(b_alu_overflow),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
    .rsp_error(b_rsp_error), .rsp_zero(b_rsp_zero), .rsp_carry(b_rsp_carry),
    .rsp_overflow(b_rsp_overflow), .busy(b_busy), .err_count(b_err_count)
  );

  // Behavioural ALU: {error, zero, carry, overflow, result[7:0]}
  function automatic logic [11:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       e, c, v;
    s = 9'd0; r = 8'd0; e = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD:    begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB:    begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_DIVIDE: if (b == 8'd0) e = 1'b1; else r = a / b;
      default:   e = 1'b1;
    endcase
    return {e, (!e && (r == 8'd0)), c, v, r};
  endfunction

  logic [7:0] ra [0:3];
  logic [7:0] rb [0:3];
  always @(posedge clk) if (alu_write_en)   ra[alu_write_addr]   <= alu_write_data;
  always @(posedge clk) if (b_alu_write_en) rb[b_alu_write_addr] <= b_alu_write_data;
  assign {alu_error, alu_zero, alu_carry, alu_overflow, alu_result} = alu_model(ra[0], ra[1], ra[2]);
  assign {b_alu_error, b_alu_zero, b_alu_carry, b_alu_overflow, b_alu_result} = alu_model(rb[0], rb[1], rb[2]);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;
  wr_t         wlog[$];
  logic [31:0] cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (alu_write_en) begin
      wlog.push_back('{addr: alu_write_addr, data: alu_write_data, cyc: cyc});
    end else begin
      chk("idle_write_bus_zero", {22'd0, alu_write_addr, alu_write_data}, 32'd0);
    end
  end

  typedef struct packed {
    logic [7:0] res;
    logic       err, zero, carry, ovf;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] op, a, b;
    int         hold;
    exp_t       ex;
  } vec_t;
  vec_t vecs[10];

  logic [7:0] sh [0:2];
  bit         shv[0:2];
  int         exp_errcnt = 0;

  function automatic bit need_write(input int idx, input logic [7:0] v);
    return !(SKIP_EN && shv[idx] && (sh[idx] == v));
  endfunction

  task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input exp_t ex);
    int         lat, nexp;
    logic [1:0] ea[3];
    logic [7:0] ed[3];
    logic [11:0] snap;
    exp_t       got;
    nexp = 0;
    if (need_write(1, a))  begin ea[nexp] = 2'd1; ed[nexp] = a;  nexp++; end
    if (need_write(2, b))  begin ea[nexp] = 2'd2; ed[nexp] = b;  nexp++; end
    if (need_write(0, op)) begin ea[nexp] = 2'd0; ed[nexp] = op; nexp++; end
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    wlog.delete();
    sbq.push_back(ex);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = ~op; cmd_a = ~a; cmd_b = 8'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      chk("busy_not_ready", {busy, cmd_ready}, 2'b10);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, nexp + A_SETTLE);
    chk("write_count", wlog.size(), nexp);
    for (int i = 0; i < nexp && i < wlog.size(); i++) begin
      chk("write_addr", wlog[i].addr, ea[i]);
      chk("write_data", wlog[i].data, ed[i]);
      chk("write_consecutive", wlog[i].cyc - wlog[0].cyc, i);
    end
    if (need_write(1, a))  begin sh[1] = a;  shv[1] = 1'b1; end
    if (need_write(2, b))  begin sh[2] = b;  shv[2] = 1'b1; end
    if (need_write(0, op)) begin sh[0] = op; shv[0] = 1'b1; end
    snap = {rsp_error, rsp_zero, rsp_carry, rsp_overflow, rsp_result};
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_rsp_stable", {rsp_error, rsp_zero, rsp_carry, rsp_overflow, rsp_result}, snap);
      chk("bp_cmd_ready_low", cmd_ready, 0);
      cmd_valid = i[0];
      cmd_a = 8'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (sbq.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      got = sbq.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, got.res);
      chk("rsp_flags", {rsp_error, rsp_zero, rsp_carry, rsp_overflow},
          {got.err, got.zero, got.carry, got.ovf});
      if (got.err && exp_errcnt < 255) exp_errcnt++;
    end
    @(negedge clk);
    chk("post_hs_valid_low", rsp_valid, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
    chk("err_count", err_count, exp_errcnt);
  endtask

  initial begin
    int lat;
    vecs[0] = '{OP_ADD,    8'h0F, 8'h01, 0, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{OP_DIVIDE, 8'h20, 8'h00, 0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{OP_ADD,    8'hFF, 8'h01, 6, '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[3] = '{OP_SUB,    8'h10, 8'h20, 0, '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[4] = '{OP_ADD,    8'h7F, 8'h01, 0, '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{OP_XOR,    8'hAA, 8'hAA, 0, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{OP_DIVIDE, 8'h64, 8'h07, 2, '{8'h0E, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{8'h3C,     8'h12, 8'h34, 0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{OP_AND,    8'hF0, 8'h3C, 0, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9] = '{OP_OR,     8'h0F, 8'hF0, 0, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin sh[i] = 8'd0; shv[i] = 1'b0; end

    rstN = 1'b0;
    cmd_valid = 1'b0; cmd_op = 8'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_op = 8'd0; b_cmd_a = 8'd0; b_cmd_b = 8'd0; b_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_outputs_zero", {busy, rsp_valid, alu_write_en, rsp_error, rsp_zero, rsp_carry, rsp_overflow}, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_err_count", err_count, 0);
    rstN = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].ex);
    end

    // Repeat of an identical ADD, then only b changes.
    run_op(OP_ADD, 8'h0F, 8'h01, 0, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op(OP_ADD, 8'h0F, 8'h01, 0, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op(OP_ADD, 8'h0F, 8'h02, 0, '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset asserted while the sequencer is in WR_B.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 8'h11; cmd_b = 8'h22; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wr_b_before_reset", {alu_write_en, alu_write_addr}, 3'b110);
    rstN = 1'b0;
    #1;
    chk("reset_mid_write_en", alu_write_en, 0);
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) shv[i] = 1'b0;
    exp_errcnt = 0;
    wlog.delete();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_cmd_ready", cmd_ready, 1);
    chk("after_reset_err_count", err_count, 0);
    chk("after_reset_no_writes", wlog.size(), 0);
    run_op(OP_ADD, 8'h11, 8'h22, 0, '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0});

    // SETTLE_CYCLES=3, 2-bit error counter: five invalid opcodes.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b_cmd_ready", b_cmd_ready, 1);
      b_cmd_valid = 1'b1;
      b_cmd_op = 8'hF0 + 8'(k);
      b_cmd_a = 8'(k);
      b_cmd_b = 8'(k + 1);
      @(posedge clk);
      @(negedge clk);
      b_cmd_valid = 1'b0;
      lat = 0;
      while (!b_rsp_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("b_latency", lat, 6);
      chk("b_rsp_error", b_rsp_error, 1);
      @(negedge clk);
      chk("b_err_count", b_err_count, (k + 1 > 3) ? 3 : k + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
